// File: rtl/prog_counter_pkg.sv
// Shared encodings for the programmable counter: operating modes and FSM states.
package prog_counter_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HOLD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] MODE_WRAP    = 2'b00;
  localparam logic [1:0] MODE_SAT     = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;
  localparam logic [1:0] MODE_RSVD    = 2'b11;

  // The reserved encoding behaves exactly like wrap.
  function automatic logic is_wrap(input logic [1:0] mode);
    return (mode == MODE_WRAP) || (mode == MODE_RSVD);
  endfunction

endpackage

// File: rtl/prog_counter_step.sv
// Combinational next-value datapath: step add/subtract, boundary detect, bound values
// and load clamping for the programmable counter.
module prog_counter_step
  import prog_counter_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int COUNT_FROM = 0,
  parameter int COUNT_TO   = 10,
  parameter int STEP       = 1
) (
  input  logic [DATA_WIDTH-1:0] count,
  input  logic                  dir,
  input  logic [DATA_WIDTH-1:0] load_value,
  output logic [DATA_WIDTH-1:0] step_value,
  output logic                  boundary,
  output logic [DATA_WIDTH-1:0] wrap_value,
  output logic [DATA_WIDTH-1:0] sat_value,
  output logic [DATA_WIDTH-1:0] load_clamped
);

  localparam int XW = DATA_WIDTH + 1;
  localparam logic [DATA_WIDTH-1:0] FROM_W = DATA_WIDTH'(COUNT_FROM);
  localparam logic [DATA_WIDTH-1:0] TO_W   = DATA_WIDTH'(COUNT_TO);
  localparam logic [DATA_WIDTH-1:0] STEP_W = DATA_WIDTH'(STEP);
  localparam logic [XW-1:0] TO_X    = XW'(COUNT_TO);
  localparam logic [XW-1:0] STEP_X  = XW'(STEP);
  // count - STEP < COUNT_FROM rewritten as count < COUNT_FROM + STEP to avoid underflow.
  localparam logic [XW-1:0] LOW_X   = XW'(COUNT_FROM) + XW'(STEP);

  logic [XW-1:0] count_x;
  logic [XW-1:0] up_x;

  assign count_x = {1'b0, count};
  assign up_x    = count_x + STEP_X;

  assign boundary   = dir ? (up_x > TO_X) : (count_x < LOW_X);
  assign step_value = dir ? (count + STEP_W) : (count - STEP_W);
  assign wrap_value = dir ? FROM_W : TO_W;
  assign sat_value  = dir ? TO_W : FROM_W;

  always_comb begin
    load_clamped = load_value;
    if (load_value < FROM_W) begin
      load_clamped = FROM_W;
    end else if (load_value > TO_W) begin
      load_clamped = TO_W;
    end
  end

endmodule

// File: rtl/prog_counter.sv
// Programmable up/down counter with wrap, saturate and one-shot modes, parallel load
// and a registered terminal-count pulse.
module prog_counter
  import prog_counter_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int COUNT_FROM = 0,
  parameter int COUNT_TO   = 10,
  parameter int STEP       = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  dir,
  input  logic [1:0]            mode,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_value,
  output logic [DATA_WIDTH-1:0] count,
  output logic                  tc,
  output logic                  done
);

  localparam logic [DATA_WIDTH-1:0] FROM_W = DATA_WIDTH'(COUNT_FROM);
  localparam logic [DATA_WIDTH-1:0] TO_W   = DATA_WIDTH'(COUNT_TO);

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   count_q, count_d;
  logic                    tc_q, tc_d;
  logic                    done_q;

  logic [DATA_WIDTH-1:0]   step_value;
  logic                    boundary;
  logic [DATA_WIDTH-1:0]   wrap_value;
  logic [DATA_WIDTH-1:0]   sat_value;
  logic [DATA_WIDTH-1:0]   load_clamped;
  logic                    hold_up;
  logic                    hold_release;
  logic                    take_step;

  prog_counter_step #(
    .DATA_WIDTH (DATA_WIDTH),
    .COUNT_FROM (COUNT_FROM),
    .COUNT_TO   (COUNT_TO),
    .STEP       (STEP)
  ) u_step (
    .count        (count_q),
    .dir          (dir),
    .load_value   (load_value),
    .step_value   (step_value),
    .boundary     (boundary),
    .wrap_value   (wrap_value),
    .sat_value    (sat_value),
    .load_clamped (load_clamped)
  );

  // HOLD is only entered at a bound, and the two bounds differ, so the count
  // itself tells which direction saturated.
  assign hold_up      = (count_q == TO_W);
  assign hold_release = (dir != hold_up) || is_wrap(mode);
  assign take_step    = en && ((state_q == ST_RUN) ||
                               ((state_q == ST_HOLD) && hold_release));

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tc_d    = 1'b0;
    if (load) begin
      count_d = load_clamped;
      state_d = ST_RUN;
    end else begin
      if ((state_q == ST_HOLD) && hold_release) begin
        state_d = ST_RUN;
      end
      if (take_step) begin
        if (!boundary) begin
          count_d = step_value;
        end else begin
          tc_d = 1'b1;
          if (is_wrap(mode)) begin
            count_d = wrap_value;
            state_d = ST_RUN;
          end else if (mode == MODE_SAT) begin
            count_d = sat_value;
            state_d = ST_HOLD;
          end else begin
            count_d = sat_value;
            state_d = ST_DONE;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      count_q <= FROM_W;
      tc_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tc_q    <= tc_d;
      done_q  <= (state_d == ST_DONE);
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign done  = done_q;

endmodule

// File: tb/tb_prog_counter.sv
// Directed bench for prog_counter: default-parameter instance plus a STEP=3 instance.
module tb_prog_counter;

  logic       clk = 1'b0;
  logic       rst;

  logic       en_a, dir_a, load_a;
  logic [1:0] mode_a;
  logic [7:0] lv_a;
  logic [7:0] count_a;
  logic       tc_a, done_a;

  logic       en_b, dir_b, load_b;
  logic [1:0] mode_b;
  logic [7:0] lv_b;
  logic [7:0] count_b;
  logic       tc_b, done_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  prog_counter dut_a (
    .clk        (clk),
    .rst        (rst),
    .en         (en_a),
    .dir        (dir_a),
    .mode       (mode_a),
    .load       (load_a),
    .load_value (lv_a),
    .count      (count_a),
    .tc         (tc_a),
    .done       (done_a)
  );

  prog_counter #(.DATA_WIDTH(8), .COUNT_FROM(0), .COUNT_TO(10), .STEP(3)) dut_b (
    .clk        (clk),
    .rst        (rst),
    .en         (en_b),
    .dir        (dir_b),
    .mode       (mode_b),
    .load       (load_b),
    .load_value (lv_b),
    .count      (count_b),
    .tc         (tc_b),
    .done       (done_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en_a = 1'b1; dir_a = 1'b1; mode_a = 2'b00; load_a = 1'b1; lv_a = 8'd7;
    en_b = 1'b0; dir_b = 1'b1; mode_b = 2'b01; load_b = 1'b0; lv_b = 8'd0;
    tick();
    tick();
    checks++;
    if (count_a !== 8'd0 || tc_a !== 1'b0 || done_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_a: count=%0d tc=%b done=%b, want count=0 tc=0 done=0", count_a, tc_a, done_a);
    end
    checks++;
    if (count_b !== 8'd0 || tc_b !== 1'b0 || done_b !== 1'b0) begin
      errors++;
      $display("FAIL reset_b: count=%0d tc=%b done=%b, want count=0 tc=0 done=0", count_b, tc_b, done_b);
    end
    rst = 1'b0; load_a = 1'b0; en_a = 1'b0;
  endtask

  task automatic test_wrap();
    int exp_c;
    exp_c = 0;
    en_a = 1'b1; dir_a = 1'b1; mode_a = 2'b00;
    for (int i = 0; i < 12; i++) begin
      tick();
      exp_c = (exp_c == 10) ? 0 : exp_c + 1;
      checks++;
      if (count_a !== 8'(exp_c) || tc_a !== (exp_c == 0)) begin
        errors++;
        $display("FAIL wrap_up[%0d]: count=%0d tc=%b, want count=%0d tc=%b", i, count_a, tc_a, exp_c, (exp_c == 0));
      end
    end
    // count is 1: down to 0 normally, then wrap to 10 with tc.
    dir_a = 1'b0;
    tick();
    checks++;
    if (count_a !== 8'd0 || tc_a !== 1'b0) begin
      errors++;
      $display("FAIL wrap_down_step: count=%0d tc=%b, want count=0 tc=0", count_a, tc_a);
    end
    tick();
    checks++;
    if (count_a !== 8'd10 || tc_a !== 1'b1) begin
      errors++;
      $display("FAIL wrap_down_bound: count=%0d tc=%b, want count=10 tc=1", count_a, tc_a);
    end
    en_a = 1'b0;
  endtask

  task automatic test_saturate();
    int exp_c [5] = '{3, 6, 9, 10, 10};
    bit exp_t [5] = '{0, 0, 0, 1, 0};
    en_b = 1'b1; dir_b = 1'b1; mode_b = 2'b01;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (count_b !== 8'(exp_c[i]) || tc_b !== exp_t[i] || done_b !== 1'b0) begin
        errors++;
        $display("FAIL sat_up[%0d]: count=%0d tc=%b done=%b, want count=%0d tc=%b done=0", i, count_b, tc_b, done_b, exp_c[i], exp_t[i]);
      end
    end
    dir_b = 1'b0;
    tick();
    checks++;
    if (count_b !== 8'd7 || tc_b !== 1'b0) begin
      errors++;
      $display("FAIL sat_release: count=%0d tc=%b, want count=7 tc=0", count_b, tc_b);
    end
    en_b = 1'b0;
  endtask

  task automatic test_oneshot();
    int exp_c [7] = '{4, 3, 2, 1, 0, 0, 0};
    bit exp_t [7] = '{0, 0, 0, 0, 0, 1, 0};
    bit exp_d [7] = '{0, 0, 0, 0, 0, 1, 1};
    mode_a = 2'b10; dir_a = 1'b0; en_a = 1'b0; load_a = 1'b1; lv_a = 8'd4;
    for (int i = 0; i < 7; i++) begin
      tick();
      load_a = 1'b0; en_a = 1'b1;
      checks++;
      if (count_a !== 8'(exp_c[i]) || tc_a !== exp_t[i] || done_a !== exp_d[i]) begin
        errors++;
        $display("FAIL oneshot[%0d]: count=%0d tc=%b done=%b, want count=%0d tc=%b done=%b", i, count_a, tc_a, done_a, exp_c[i], exp_t[i], exp_d[i]);
      end
    end
    dir_a = 1'b1;
    tick();
    checks++;
    if (count_a !== 8'd0 || done_a !== 1'b1) begin
      errors++;
      $display("FAIL oneshot_ignore_dir: count=%0d done=%b, want count=0 done=1", count_a, done_a);
    end
    en_a = 1'b0; load_a = 1'b1; lv_a = 8'd6;
    tick();
    load_a = 1'b0;
    checks++;
    if (count_a !== 8'd6 || done_a !== 1'b0 || tc_a !== 1'b0) begin
      errors++;
      $display("FAIL oneshot_reload: count=%0d done=%b tc=%b, want count=6 done=0 tc=0", count_a, done_a, tc_a);
    end
  endtask

  task automatic test_load_priority();
    mode_a = 2'b00; dir_a = 1'b1; en_a = 1'b1; load_a = 1'b1; lv_a = 8'd200;
    tick();
    checks++;
    if (count_a !== 8'd10 || tc_a !== 1'b0) begin
      errors++;
      $display("FAIL load_clamp: count=%0d tc=%b, want count=10 tc=0", count_a, tc_a);
    end
    load_a = 1'b0; en_a = 1'b0;
  endtask

  task automatic test_reserved_mode();
    mode_a = 2'b11; dir_a = 1'b1; load_a = 1'b1; lv_a = 8'd10;
    tick();
    load_a = 1'b0; en_a = 1'b1;
    tick();
    checks++;
    if (count_a !== 8'd0 || tc_a !== 1'b1 || done_a !== 1'b0) begin
      errors++;
      $display("FAIL reserved_wrap: count=%0d tc=%b done=%b, want count=0 tc=1 done=0", count_a, tc_a, done_a);
    end
    en_a = 1'b0;
  endtask

  task automatic test_reset_in_done();
    mode_a = 2'b10; dir_a = 1'b1; load_a = 1'b1; lv_a = 8'd9;
    tick();
    load_a = 1'b0; en_a = 1'b1;
    tick();
    tick();
    checks++;
    if (count_a !== 8'd10 || tc_a !== 1'b1 || done_a !== 1'b1) begin
      errors++;
      $display("FAIL done_entry: count=%0d tc=%b done=%b, want count=10 tc=1 done=1", count_a, tc_a, done_a);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0; mode_a = 2'b00;
    checks++;
    if (count_a !== 8'd0 || tc_a !== 1'b0 || done_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_from_done: count=%0d tc=%b done=%b, want count=0 tc=0 done=0", count_a, tc_a, done_a);
    end
    tick();
    checks++;
    if (count_a !== 8'd1 || done_a !== 1'b0) begin
      errors++;
      $display("FAIL resume_after_reset: count=%0d done=%b, want count=1 done=0", count_a, done_a);
    end
    en_a = 1'b0;
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_saturate();
    test_oneshot();
    test_load_priority();
    test_reserved_mode();
    test_reset_in_done();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_counter.md
PROG_COUNTER -- requirements
Module: prog_counter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the count width in bits.
REQ-002 The block SHALL have parameter COUNT_FROM, default 0, giving the lower bound of the count range.
REQ-003 The block SHALL have parameter COUNT_TO, default 10, giving the upper bound of the count range; COUNT_FROM < COUNT_TO < 2^DATA_WIDTH.
REQ-004 The block SHALL have parameter STEP, default 1, giving the increment per enabled cycle; 1 <= STEP <= COUNT_TO-COUNT_FROM.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port en, input, 1 bit: advance the count by one step this cycle.
REQ-008 The block SHALL have port dir, input, 1 bit: 1 = count up, 0 = count down.
REQ-009 The block SHALL have port mode, input, 2 bits: 00 wrap, 01 saturate, 10 one-shot, 11 reserved and treated as wrap.
REQ-010 The block SHALL have port load, input, 1 bit: load load_value this cycle.
REQ-011 The block SHALL have port load_value, input, DATA_WIDTH bits: the value to load.
REQ-012 The block SHALL have port count, output, DATA_WIDTH bits: the registered count.
REQ-013 The block SHALL have port tc, output, 1 bit: registered one-cycle terminal-count pulse.
REQ-014 The block SHALL have port done, output, 1 bit: registered; high while the FSM is in DONE.

Function
REQ-015 The FSM SHALL have exactly three states: RUN, HOLD (saturated) and DONE (one-shot finished).
REQ-016 Priority SHALL be rst > load > en; with none asserted, all registers SHALL hold.
REQ-017 On load: count = load_value clamped to [COUNT_FROM, COUNT_TO], FSM = RUN, tc = 0, done = 0, all in the following cycle.
REQ-018 The boundary event SHALL be an enabled step in RUN where count+STEP > COUNT_TO (up) or count-STEP < COUNT_FROM (down), evaluated in DATA_WIDTH+1 bits with no truncation.
REQ-019 An enabled step without a boundary event SHALL set count to count±STEP, with tc = 0.
REQ-020 On a boundary event in wrap mode, count SHALL be set to COUNT_FROM (up) or COUNT_TO (down), with tc = 1 for one cycle and the FSM staying in RUN.
REQ-021 On a boundary event in saturate mode, count SHALL be set to COUNT_TO (up) or COUNT_FROM (down), with tc = 1 for one cycle and FSM = HOLD.
REQ-022 In HOLD, enabled steps toward the bound SHALL leave count unchanged with tc = 0.
REQ-023 In HOLD, a dir change SHALL return the FSM to RUN, and the same cycle's enabled step SHALL apply normally.
REQ-024 On a boundary event in one-shot mode, count SHALL be set to the bound as in saturate mode, with tc = 1 for one cycle, FSM = DONE and done = 1.
REQ-025 In DONE, en and dir SHALL be ignored; the FSM SHALL exit DONE only on load or rst.
REQ-026 mode SHALL be sampled every cycle; a mode change SHALL not alter the current state, except that HOLD with mode = wrap SHALL return to RUN.
REQ-027 Latency from en to the count update SHALL be one cycle; tc SHALL be coincident with the count taking its bound or wrap value.

Reset
REQ-028 While rst is high at a rising clk edge, the block SHALL set count = COUNT_FROM, tc = 0, done = 0 and FSM = RUN, regardless of en or load.
REQ-029 A reset asserted mid-operation, including in HOLD or DONE, SHALL take effect on the next edge with no residual state.

Structure
REQ-030 Mode encodings and FSM state encodings SHALL be defined as named constants in the shared package prog_counter_pkg.
REQ-031 Next-value arithmetic (add/subtract, bound compare, clamp) SHALL be implemented in one combinational sub-module, prog_counter_step; the FSM and registers SHALL reside in prog_counter.

Verification
REQ-032 Defaults, mode = 00, dir = 1, en held high: the bench SHALL check count sequence 0,1,…,10,0,1 with tc high only in the cycle count returns to 0.
REQ-033 STEP = 3, mode = 01, dir = 1, from 0: the bench SHALL check count 0,3,6,9,10,10 with a single tc pulse at the first 10; then dir = 0 yields count 7.
REQ-034 mode = 10, dir = 0, load 4: the bench SHALL check count 4,3,2,1,0 with tc and done rising together at 0; en kept high holds count 0; load 6 clears done.
REQ-035 load = 1 and en = 1 in the same cycle with load_value = 200: the bench SHALL check count = 10 (clamped) with tc = 0.
REQ-036 rst asserted for one cycle while in DONE with count = 10: the next cycle SHALL show count = 0, done = 0 and tc = 0, with counting resuming when en = 1.
